// File: rtl/mcore_mem_req_net_adapter.sv
// rtl/mcore_mem_req_net_adapter.sv - buffered memory-request to network-message adapter
//
// Ports:
//   clk, reset (async, active-low)
//   mode, domain        : request attributes, captured with each accepted request
//   mem_req_val/rdy/msg : memory request {type, opaque, addr, len, data}
//   net_val/rdy         : network handshake for the head queue entry
//   net_msg_control     : {dest, src, seq opaque, {req_domain, type, opaque', addr, len}}
//   net_msg_data        : data field of the head entry
//   net_domain          : domain captured with the head entry
module mcore_mem_req_net_adapter #(
  parameter int          p_net_src           = 0,
  parameter int          p_num_ports         = 4,
  parameter int          p_mem_opaque_nbits  = 8,
  parameter int          p_mem_addr_nbits    = 32,
  parameter int          p_mem_data_nbits    = 32,
  parameter int          p_net_opaque_nbits  = 4,
  parameter int          p_net_srcdest_nbits = 3,
  parameter int          p_cacheline_nwords  = 4,
  parameter int          p_single_bank       = 0,
  parameter int          p_num_banks         = 2,
  parameter int          p_dest_mode         = 0,
  parameter logic [31:0] p_inst_boundary     = 32'h4000,
  parameter logic [31:0] p_data_boundary     = 32'hc000,
  parameter int          p_queue_depth       = 2,
  localparam int LEN_W  = $clog2(p_mem_data_nbits / 8),
  localparam int MSG_W  = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + LEN_W + p_mem_data_nbits,
  localparam int CTRL_W = MSG_W - p_mem_data_nbits + 1 + p_net_opaque_nbits + 2 * p_net_srcdest_nbits
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        domain,
  input  logic                        mem_req_val,
  output logic                        mem_req_rdy,
  input  logic [MSG_W-1:0]            mem_req_msg,
  output logic                        net_val,
  input  logic                        net_rdy,
  output logic [CTRL_W-1:0]           net_msg_control,
  output logic [p_mem_data_nbits-1:0] net_msg_data,
  output logic                        net_domain
);

  localparam int MO     = p_mem_opaque_nbits;
  localparam int MA     = p_mem_addr_nbits;
  localparam int MD     = p_mem_data_nbits;
  localparam int NO     = p_net_opaque_nbits;
  localparam int NS     = p_net_srcdest_nbits;
  localparam int LSB    = 2 + $clog2(p_cacheline_nwords);
  localparam int BANK_W = (p_num_banks > 1) ? $clog2(p_num_banks) : 1;
  localparam int PTR_W  = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;
  localparam int CNT_W  = $clog2(p_queue_depth + 1);

  localparam logic [NS-1:0] SRC    = NS'(p_net_src);
  localparam logic [MA-1:0] INST_B = MA'(p_inst_boundary);
  localparam logic [MA-1:0] DATA_B = MA'(p_data_boundary);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

  state_t             state, state_next;
  logic               last_domain;
  logic               rst_done;
  logic [NO-1:0]      seq;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   head, tail;
  logic               enq, deq, full, empty;

  logic [CTRL_W-1:0]  q_ctrl [p_queue_depth];
  logic [MD-1:0]      q_data [p_queue_depth];
  logic               q_dom  [p_queue_depth];

  logic [2:0]         req_type;
  logic [MO-1:0]      req_opaque;
  logic [MA-1:0]      req_addr;
  logic [LEN_W-1:0]   req_len;
  logic [MD-1:0]      req_data;
  logic [NS-1:0]      dest;
  logic [CTRL_W-1:0]  ctrl_in;
  logic               unused_inputs;

  assign req_type   = mem_req_msg[MSG_W-1 -: 3];
  assign req_opaque = mem_req_msg[MD+LEN_W+MA +: MO];
  assign req_addr   = mem_req_msg[MD+LEN_W +: MA];
  assign req_len    = mem_req_msg[MD +: LEN_W];
  assign req_data   = mem_req_msg[MD-1:0];

  // The top opaque bits are replaced by the source id, so the originals are dropped.
  assign unused_inputs = ^{req_opaque[MO-1 -: NS], mode};

  always_comb begin
    dest = '0;
    if (p_single_bank == 0) begin
      if (p_dest_mode == 1) begin
        if (p_num_banks > 1) dest = NS'(req_addr[LSB +: BANK_W]);
      end else if (mode) begin
        dest = (req_addr < DATA_B) ? '0 : NS'(1);
      end else begin
        dest = (req_addr < INST_B) ? '0 : NS'(1);
      end
    end
  end

  assign ctrl_in = {dest, SRC, seq, SRC[0], req_type, SRC, req_opaque[MO-NS-1:0], req_addr, req_len};

  assign full  = (count == CNT_W'(p_queue_depth));
  assign empty = (count == '0);
  assign enq   = mem_req_val && mem_req_rdy;
  assign deq   = net_val && net_rdy;

  // A request of the other domain is held off until every older entry has left.
  // rst_done keeps rdy low while reset is asserted and for the first edge after release.
  always_comb begin
    state_next  = state;
    mem_req_rdy = 1'b0;
    case (state)
      S_IDLE: begin
        mem_req_rdy = rst_done && !full;
        if (enq) state_next = S_BUSY;
      end
      S_BUSY: begin
        mem_req_rdy = rst_done && !full && (domain == last_domain);
        if (mem_req_val && (domain != last_domain)) begin
          state_next = (deq && count == CNT_W'(1)) ? S_IDLE : S_DRAIN;
        end else if (!enq && deq && count == CNT_W'(1)) begin
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (empty || (deq && count == CNT_W'(1))) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_done    <= 1'b0;
      last_domain <= 1'b0;
      seq         <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      rst_done <= 1'b1;
      if (enq && state == S_IDLE) last_domain <= domain;
      if (enq) begin
        seq  <= seq + NO'(1);
        tail <= (tail == PTR_W'(p_queue_depth - 1)) ? '0 : tail + PTR_W'(1);
      end
      if (deq) head <= (head == PTR_W'(p_queue_depth - 1)) ? '0 : head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_ctrl[tail] <= ctrl_in;
      q_data[tail] <= req_data;
      q_dom[tail]  <= domain;
    end
  end

  assign net_val         = !empty;
  assign net_msg_control = empty ? '0 : q_ctrl[head];
  assign net_msg_data    = empty ? '0 : q_data[head];
  assign net_domain      = empty ? 1'b0 : q_dom[head];

endmodule

// File: tb/tb_mcore_mem_req_net_adapter.sv
// tb/tb_mcore_mem_req_net_adapter.sv - scoreboard bench for mcore_mem_req_net_adapter
module tb_mcore_mem_req_net_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mode, domain, mem_req_val, mem_req_rdy;
  logic        net_val, net_rdy, net_domain;
  logic [2:0]  r_type;
  logic [7:0]  r_opq;
  logic [31:0] r_addr;
  logic [1:0]  r_len;
  logic [31:0] r_data;
  logic [76:0] mem_req_msg;
  logic [55:0] net_msg_control;
  logic [31:0] net_msg_data;

  logic        il_val, il_rdy, il_net_val, il_net_domain;
  logic [31:0] il_addr;
  logic [76:0] il_msg;
  logic [55:0] il_ctrl;
  logic [31:0] il_data;

  assign mem_req_msg = {r_type, r_opq, r_addr, r_len, r_data};
  assign il_msg      = {3'd0, 8'h00, il_addr, 2'd0, il_addr ^ 32'h5a5a_0000};

  mcore_mem_req_net_adapter #(.p_net_src(5)) dut (
    .clk(clk), .reset(reset), .mode(mode), .domain(domain),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .net_val(net_val), .net_rdy(net_rdy), .net_msg_control(net_msg_control),
    .net_msg_data(net_msg_data), .net_domain(net_domain)
  );

  mcore_mem_req_net_adapter #(.p_net_src(5), .p_dest_mode(1), .p_num_banks(4)) dut_il (
    .clk(clk), .reset(reset), .mode(1'b0), .domain(1'b0),
    .mem_req_val(il_val), .mem_req_rdy(il_rdy), .mem_req_msg(il_msg),
    .net_val(il_net_val), .net_rdy(1'b1), .net_msg_control(il_ctrl),
    .net_msg_data(il_data), .net_domain(il_net_domain)
  );

  typedef struct {
    logic [55:0] ctrl;
    logic [31:0] data;
    logic        dom;
  } ent_t;

  ent_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         pops   = 0;
  int         p0;
  logic [3:0] seq_m  = 4'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] bdest(input logic md, input logic [31:0] a);
    if (md) return (a < 32'hc000) ? 3'd0 : 3'd1;
    return (a < 32'h4000) ? 3'd0 : 3'd1;
  endfunction

  function automatic logic [55:0] exp_ctrl(input logic [2:0] d, input logic [3:0] sq,
                                           input logic [2:0] t, input logic [7:0] o,
                                           input logic [31:0] a, input logic [1:0] l);
    logic [2:0] src;
    src = 3'd5;
    return {d, src, sq, src[0], t, src, o[4:0], a, l};
  endfunction

  task automatic set_req(input logic md, input logic dm, input logic [31:0] a,
                         input logic [31:0] dt, input logic [7:0] o);
    mode        = md;
    domain      = dm;
    r_addr      = a;
    r_data      = dt;
    r_opq       = o;
    r_type      = 3'($urandom());
    r_len       = 2'($urandom());
    mem_req_val = 1'b1;
  endtask

  // One cycle: at the falling edge check rdy, retire the head if handshaken,
  // record an accepted request; then advance past the rising edge.
  task automatic step(input bit rc, input bit er);
    ent_t e;
    @(negedge clk);
    if (rc) chk("mem_req_rdy", mem_req_rdy, er);
    if (net_val && net_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_msg", net_val, 1'b0);
      end else begin
        e = sb.pop_front();
        pops++;
        chk("net_ctrl", net_msg_control, e.ctrl);
        chk("net_data", net_msg_data, e.data);
        chk("net_domain", net_domain, e.dom);
      end
    end
    if (mem_req_val && mem_req_rdy) begin
      e.ctrl = exp_ctrl(bdest(mode, r_addr), seq_m, r_type, r_opq, r_addr, r_len);
      e.data = r_data;
      e.dom  = domain;
      sb.push_back(e);
      seq_m++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; mem_req_val = 1'b0; net_rdy = 1'b0; mode = 1'b0; domain = 1'b0;
    r_type = '0; r_opq = '0; r_addr = '0; r_len = '0; r_data = '0;
    il_val = 1'b0; il_addr = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_net_val", net_val, 1'b0);
    chk("rst_ctrl", net_msg_control, 56'd0);
    chk("rst_data", net_msg_data, 32'd0);
    chk("rst_domain", net_domain, 1'b0);
    chk("rst_rdy", mem_req_rdy, 1'b0);
    reset = 1'b1;
    step(0, 0);
    chk("rdy_after_reset", mem_req_rdy, 1'b1);

    // boundary destination mapping and N+1 latency
    net_rdy = 1'b1;
    set_req(1'b1, 1'b0, 32'h0000_c010, 32'hdead_beef, 8'ha7);
    step(1, 1);
    chk("lat_net_val", net_val, 1'b1);
    chk("dest_data_c010", net_msg_control[55:53], 3'd1);
    chk("src_field", net_msg_control[52:50], 3'd5);
    chk("first_opaque", net_msg_control[49:46], 4'd0);
    chk("first_data", net_msg_data, 32'hdead_beef);
    set_req(1'b0, 1'b0, 32'h0000_c010, 32'h1234_5678, 8'h3c);
    step(1, 1);
    chk("dest_inst_c010", net_msg_control[55:53], 3'd1);
    set_req(1'b0, 1'b0, 32'h0000_3ff0, 32'h0bad_f00d, 8'hff);
    step(1, 1);
    chk("dest_inst_3ff0", net_msg_control[55:53], 3'd0);
    mem_req_val = 1'b0;
    step(0, 0);
    chk("idle_net_val", net_val, 1'b0);

    // back-to-back, sequence number wraps
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      set_req(1'($urandom()), 1'b0, $urandom() & 32'h0000_ffff, $urandom(), 8'($urandom()));
      step(1, 1);
    end
    mem_req_val = 1'b0;
    step(0, 0);
    chk("b2b_pops", pops - p0, 20);

    // backpressure with a depth-2 queue
    net_rdy = 1'b0;
    set_req(1'b0, 1'b0, 32'h100, 32'haaaa_0001, 8'h01); step(1, 1);
    set_req(1'b1, 1'b0, 32'hd000, 32'haaaa_0002, 8'h02); step(1, 1);
    set_req(1'b0, 1'b0, 32'h5000, 32'haaaa_0003, 8'h03); step(1, 0);
    net_rdy = 1'b1;
    step(1, 0);
    step(1, 1);
    mem_req_val = 1'b0;
    step(0, 0);
    chk("bp_drained", net_val, 1'b0);

    // domain switch drain
    net_rdy = 1'b0;
    set_req(1'b0, 1'b0, 32'h200, 32'hbbbb_0001, 8'h11); step(1, 1);
    set_req(1'b0, 1'b0, 32'h204, 32'hbbbb_0002, 8'h12); step(1, 1);
    set_req(1'b1, 1'b1, 32'hc100, 32'hcccc_0001, 8'h13); step(1, 0);
    net_rdy = 1'b1;
    step(1, 0);
    step(1, 0);
    step(1, 1);
    mem_req_val = 1'b0;
    chk("dom_net_val", net_val, 1'b1);
    chk("dom_net_domain", net_domain, 1'b1);
    step(0, 0);

    // asynchronous reset with entries queued
    net_rdy = 1'b0;
    set_req(1'b0, 1'b1, 32'h300, 32'hdddd_0001, 8'h21); step(1, 1);
    set_req(1'b0, 1'b1, 32'h304, 32'hdddd_0002, 8'h22); step(1, 1);
    mem_req_val = 1'b0;
    chk("pre_rst_val", net_val, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_rst_val", net_val, 1'b0);
    chk("async_rst_ctrl", net_msg_control, 56'd0);
    chk("async_rst_data", net_msg_data, 32'd0);
    chk("async_rst_rdy", mem_req_rdy, 1'b0);
    sb.delete();
    seq_m = 4'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 0);
    chk("no_stale_val", net_val, 1'b0);
    net_rdy = 1'b1;
    set_req(1'b1, 1'b0, 32'hc004, 32'heeee_0001, 8'h31); step(1, 1);
    chk("seq_restart", net_msg_control[49:46], 4'd0);
    mem_req_val = 1'b0;
    step(0, 0);

    // line-interleaved destination, 4 banks, 4-word lines
    il_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      il_addr = 32'(i * 16);
      @(negedge clk);
      chk("il_rdy", il_rdy, 1'b1);
      @(posedge clk); #1;
      chk("il_net_val", il_net_val, 1'b1);
      chk("il_dest", il_ctrl[55:53], 3'((il_addr >> 4) & 32'h3));
      chk("il_data", il_data, il_addr ^ 32'h5a5a_0000);
      chk("il_domain", il_net_domain, 1'b0);
    end
    il_val = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcore_mem_req_net_adapter.md
Name: mcore_mem_req_net_adapter

Overview:
- Parametrised, buffered successor to the combinational memory-request to network-message adapter between core/cache request ports and the split control/data request network.
- Accepts memory requests over val/rdy and computes the destination bank (single, boundary or line-interleaved). Queues each request as a {control, data, domain} entry and emits it over val/rdy with a rolling network opaque sequence number.
- Enforces a domain-switch drain: requests of a new security domain never share the queue with older requests of the other domain.

Parameters:
- p_net_src, 0, source id (core id) packed in net src and opaque high bits
- p_num_ports, 4, number of network ports
- p_mem_opaque_nbits, 8, mem opaque width (mo)
- p_mem_addr_nbits, 32, mem address width (ma)
- p_mem_data_nbits, 32, mem data width (md)
- p_net_opaque_nbits, 4, net opaque width (no); holds sequence counter
- p_net_srcdest_nbits, 3, net src/dest width (ns)
- p_cacheline_nwords, 4, words per line; interleave lsb = 2+$clog2(nwords)
- p_single_bank, 0, 1: dest always 0
- p_num_banks, 2, bank count, power of two, <= 2^ns
- p_dest_mode, 0, 0: boundary mapping; 1: line-interleaved mapping
- p_inst_boundary, 32'h4000, mode=0 boundary: addr < value -> bank 0, else bank 1
- p_data_boundary, 32'hc000, mode=1 boundary: addr < value -> bank 0, else bank 1
- p_queue_depth, 2, entries, >= 1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- mode  in  1  0: inst, 1: data; sampled with request
- domain  in  1  security domain of the current request; sampled with request
- mem_req_val  in  1  request valid
- mem_req_rdy  out  1  request ready
- mem_req_msg  in  VC_MEM_REQ_MSG_NBITS(mo,ma,md)  memory request
- net_val  out  1  network message valid
- net_rdy  in  1  network ready
- net_msg_control  out  VC_NET_MSG_NBITS(npc+1,no,ns)  control message; npc = mem req nbits - md
- net_msg_data  out  md  data field of the head entry
- net_domain  out  1  domain latched with the head entry

Behaviour:
- Reset (reset=0, async): queue empty, net_val=0, net_msg_control=0, net_msg_data=0, net_domain=0, seq=0, last_domain=0, state IDLE. mem_req_rdy=0 while reset is asserted.
- Dest: p_single_bank -> 0.
- Dest, p_dest_mode=1: addr[lsb +: $clog2(p_num_banks)], zero-extended to ns.
- Dest, p_dest_mode=0: mode ? (addr<p_data_boundary?0:1) : (addr<p_inst_boundary?0:1).
- Control payload: {req_domain, MemReqCMsgPack(type, opaque', addr, len)}.
  - req_domain = p_net_src[0].
  - opaque' = {p_net_src[ns-1:0], opaque[mo-ns-1:0]}.
- Net header: dest as above; src = p_net_src[ns-1:0]; opaque = seq value at enqueue.
- Enqueue: mem_req_val && mem_req_rdy. Entry is written, seq increments mod 2^no and wraps 2^no-1 -> 0.
- Dequeue: net_val && net_rdy.
- Latency: an entry enqueued in cycle N is visible on net_* in cycle N+1. No bypass.
- Throughput: 1 req/cycle when depth >= 2 and net_rdy=1.
- net_* are driven from the head entry; outputs are 0 when the queue is empty.
- mem_req_rdy = !full && !(state==DRAIN). No enqueue into a full queue, even with a same-cycle dequeue.
- FSM:
  - IDLE (empty): accept any domain; last_domain <= domain; -> BUSY.
  - BUSY: a request with domain==last_domain is accepted. domain!=last_domain -> DRAIN with rdy=0; the head still drains. Queue empties with no accept -> IDLE.
  - DRAIN: rdy=0. On the last dequeue (count 1->0) -> IDLE; the new-domain request is accepted the following cycle.
- Simultaneous enq+deq in BUSY: count unchanged, pointers advance, wrap at p_queue_depth-1 -> 0.
- mode and domain are captured per entry; later changes never alter queued entries.
- Reset mid-transfer drops all entries, no partial output.

Test Plan:
- Reset, then a mode=1, addr=32'h0000_c010, p_dest_mode=0 request: next cycle net_val=1, dest=1, src=p_net_src, opaque=0, net_msg_data = request data. Same addr with mode=0 -> dest=1; addr 32'h3ff0, mode=0 -> dest=0.
- p_dest_mode=1, p_num_banks=4, nwords=4: addrs 0x00, 0x10, 0x20, 0x30, 0x40 -> dests 0, 1, 2, 3, 0.
- Back-to-back 20 requests with net_rdy=1, no=4: one message per cycle, opaques 0..15, 0..3 (wrap). mem opaque high ns bits equal p_net_src.
- Depth 2, net_rdy=0, 3 requests: 2 accepted, mem_req_rdy=0. Raise net_rdy: FIFO order preserved, third request accepted after the first dequeue.
- Queue holds 2 domain-0 entries, domain-1 request arrives: mem_req_rdy=0 until both are dequeued. Accepted the cycle after empty, with net_domain=1 on output.
- Assert reset with 2 entries queued: net_val=0 immediately (async). After release, seq restarts at 0 and no stale entries appear.
